interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Owns the processor's external `interrupt`/`ack` handshake.
- Latches a request, waits for an instruction boundary, then freezes and flushes the pipeline.
- Pushes PC and flags to the stack through the data-memory port and fetches the handler address from the vector table.
- Loads the PC with the handler address, then pulses `ack`.
- Sits between the processor's PC/CCR/SP logic and the data-memory arbiter.

Parameters:
- DATA_W, 16, memory data word width.
- PC_W, 32, program counter width; pushed as two DATA_W words.
- ADDR_W, 20, data-memory address width.
- FLAGS_W, 3, CCR width (Z, N, C); zero-extended to DATA_W when pushed.
- IVT_ADDR, 0, word address of the handler-address high word; the low word is at IVT_ADDR+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- interrupt  in  1  external request; rising edge sets pending; may be held high until ack.
- safe_point  in  1  pipeline is at an instruction boundary with no branch or memory op in flight.
- pc_in  in  PC_W  PC of the next instruction to resume.
- flags_in  in  FLAGS_W  current CCR.
- sp_in  in  ADDR_W  current stack pointer (address of the next free slot).
- sp_dec  out  1  one-cycle pulse; processor decrements SP by 1.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_gnt  in  1  arbiter accepts the request this cycle.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
- mem_rdata  in  DATA_W  read data.
- stall  out  1  freeze fetch/decode.
- flush  out  1  one-cycle squash of in-flight instructions.
- pc_load  out  1  one-cycle PC overwrite strobe.
- pc_load_val  out  PC_W  handler address.
- ack  out  1  one-cycle pulse when the handler PC has been loaded.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - pending, the edge register, pc_q, flags_q and vec_q clear.
  - All outputs are 0.
  - Reset mid-sequence abandons the sequence; no further memory transactions are issued.
- Pending latch:
  - Set on a 0→1 transition of interrupt (edge register sampled every cycle).
  - Cleared in the ACK cycle.
  - An edge arriving in the ACK cycle wins: pending stays 1.
  - A level held high does not re-trigger.
- States and transitions:
  - IDLE: go to FLUSH when pending && safe_point.
  - FLUSH: stall=1, flush=1; capture pc_q←pc_in and flags_q←flags_in; go to PUSH_PCH.
  - PUSH_PCH: req=1, we=1, addr=sp_in, wdata=pc_q[PC_W-1:DATA_W]. On gnt: sp_dec=1, go to PUSH_PCL.
  - PUSH_PCL: same, with wdata=pc_q[DATA_W-1:0]; go to PUSH_FLG.
  - PUSH_FLG: same, with wdata={zeros, flags_q}; go to RD_VH.
  - RD_VH: req=1, we=0, addr=IVT_ADDR; on gnt go to WT_VH.
  - WT_VH: hold req=0; on rvalid capture the high word into vec_q; go to RD_VL.
  - RD_VL: addr=IVT_ADDR+1 (wraps modulo 2^ADDR_W); on gnt go to WT_VL.
  - WT_VL: on rvalid capture the low word into vec_q; go to LOAD.
  - LOAD: pc_load=1, pc_load_val=vec_q; go to ACK.
  - ACK: ack=1; go to IDLE.
- Stall timing: stall is 1 from FLUSH through ACK inclusive and 0 in IDLE.
- Memory request hold: mem_req, mem_addr and mem_wdata stay stable until gnt; there is no timeout.
- Latency: with gnt immediate and rvalid 1 cycle after gnt, FLUSH to ACK is exactly 10 cycles.
- Output gating: mem_addr and mem_wdata are 0 whenever mem_req=0.
- Requests during a sequence: a new edge during the sequence is recorded only if it arrives in the ACK cycle or later (pending is still 1 before that). It is serviced at the next safe_point after returning to IDLE.

Optional Feature:
- Macro: INTC_MASK_EN.
- Defined:
  - Adds input `int_mask` (1 bit).
  - The IDLE→FLUSH transition additionally requires int_mask=0.
  - pending is retained while masked.
  - Masking mid-sequence has no effect.
- Undefined: no port; behaviour is as above.

Decomposition:
- Package intc_pkg holds:
  - state enum (IDLE, FLUSH, PUSH_PCH, PUSH_PCL, PUSH_FLG, RD_VH, WT_VH, RD_VL, WT_VL, LOAD, ACK);
  - default widths;
  - IVT_ADDR default.
- Sub-module intc_pending_latch (edge detect, set/clear priority) is natural.
- The FSM and datapath registers stay in interrupt_sequencer.

Test Plan:
- Basic sequence:
  - Stimulus: rst 1 cycle; pc_in=0x0001_2345, flags_in=3'b101, sp_in=0xFFFFF; M[0]=0x0000, M[1]=0x0200; gnt immediate, rvalid +1; pulse interrupt with safe_point=1.
  - Required: writes 0x0001@0xFFFFF, 0x2345@0xFFFFE, 0x0005@0xFFFFD; 3 sp_dec pulses; pc_load_val=0x0000_0200; ack exactly 10 cycles after flush.
- Deferred entry: interrupt held high while safe_point=0 for 5 cycles → no flush until safe_point=1. Interrupt held high through ack produces exactly one sequence.
- Arbiter back-pressure: mem_gnt withheld 4 cycles in PUSH_PCL → req/addr/wdata stable throughout; sp_dec only on the gnt cycle; total latency 14 cycles.
- Request in ACK cycle: second rising edge in the ACK cycle → pending=1 after ACK; a second sequence starts at the next safe_point.
- Reset mid-operation: rst asserted in RD_VH → next cycle busy=0, stall=0, mem_req=0, pending=0; no pc_load or ack follows.
- INTC_MASK_EN: int_mask=1 with an edge → no entry, pending held; drop int_mask → entry next cycle where safe_point=1.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and default geometry for the interrupt sequencer.
package intc_pkg;

  localparam int          DEF_DATA_W   = 16;
  localparam int          DEF_PC_W     = 32;
  localparam int          DEF_ADDR_W   = 20;
  localparam int          DEF_FLAGS_W  = 3;
  localparam int unsigned DEF_IVT_ADDR = 0;

  typedef enum logic [3:0] {
    IDLE,
    FLUSH,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_FLG,
    RD_VH,
    WT_VH,
    RD_VL,
    WT_VL,
    LOAD,
    ACK
  } state_e;

endpackage

// File: rtl/intc_pending_latch.sv
// Rising-edge detector plus sticky pending flag for the external interrupt line.
module intc_pending_latch (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic clr_i,
  output logic pending_o
);

  logic req_q;
  logic pending_q;
  logic pending_d;
  logic rise;

  assign rise = req_i & ~req_q;
  // Set beats clear so an edge landing in the ACK cycle is not lost.
  assign pending_d = rise | (pending_q & ~clr_i);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      req_q     <= req_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: flush, push PC/flags, fetch vector, load PC, ack.
// Optional build macro INTC_MASK_EN adds an int_mask input that blocks entry.
module interrupt_sequencer
  import intc_pkg::*;
#(
  parameter int          DATA_W   = DEF_DATA_W,
  parameter int          PC_W     = DEF_PC_W,
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          FLAGS_W  = DEF_FLAGS_W,
  parameter int unsigned IVT_ADDR = DEF_IVT_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               interrupt,
  input  logic               safe_point,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [FLAGS_W-1:0] flags_in,
  input  logic [ADDR_W-1:0]  sp_in,
  output logic               sp_dec,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               stall,
  output logic               flush,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               ack,
`ifdef INTC_MASK_EN
  input  logic               int_mask,
`endif
  output logic               busy
);

  localparam logic [ADDR_W-1:0] IVT_HI = ADDR_W'(IVT_ADDR);
  localparam logic [ADDR_W-1:0] IVT_LO = IVT_HI + ADDR_W'(1);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic [PC_W-1:0]    vec_q, vec_d;
  logic               pending;
  logic               masked;

`ifdef INTC_MASK_EN
  assign masked = int_mask;
`else
  assign masked = 1'b0;
`endif

  intc_pending_latch u_pending (
    .clk       (clk),
    .rst       (rst),
    .req_i     (interrupt),
    .clr_i     (state_q == ACK),
    .pending_o (pending)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE:     if (pending && safe_point && !masked) state_d = FLUSH;
      FLUSH: begin
        pc_d    = pc_in;
        flags_d = flags_in;
        state_d = PUSH_PCH;
      end
      PUSH_PCH: if (mem_gnt) state_d = PUSH_PCL;
      PUSH_PCL: if (mem_gnt) state_d = PUSH_FLG;
      PUSH_FLG: if (mem_gnt) state_d = RD_VH;
      RD_VH:    if (mem_gnt) state_d = WT_VH;
      WT_VH: if (mem_rvalid) begin
        vec_d[PC_W-1:DATA_W] = mem_rdata;
        state_d              = RD_VL;
      end
      RD_VL:    if (mem_gnt) state_d = WT_VL;
      WT_VL: if (mem_rvalid) begin
        vec_d[DATA_W-1:0] = mem_rdata;
        state_d           = LOAD;
      end
      LOAD:     state_d = ACK;
      ACK:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      vec_q   <= vec_d;
    end
  end

  // Outputs are forced low while rst is high so no transaction can slip out.
  always_comb begin
    sp_dec      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    stall       = 1'b0;
    flush       = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    ack         = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      busy  = (state_q != IDLE);
      stall = busy;
      case (state_q)
        FLUSH: flush = 1'b1;
        PUSH_PCH, PUSH_PCL, PUSH_FLG: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = sp_in;
          sp_dec   = mem_gnt;
          if (state_q == PUSH_PCH)      mem_wdata = pc_q[PC_W-1:DATA_W];
          else if (state_q == PUSH_PCL) mem_wdata = pc_q[DATA_W-1:0];
          else                          mem_wdata = DATA_W'(flags_q);
        end
        RD_VH: begin
          mem_req  = 1'b1;
          mem_addr = IVT_HI;
        end
        RD_VL: begin
          mem_req  = 1'b1;
          mem_addr = IVT_LO;
        end
        LOAD: begin
          pc_load     = 1'b1;
          pc_load_val = vec_q;
        end
        ACK:     ack = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner cases, and
// randomized sequences checked against an arithmetic model of the entry rules.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic [31:0]      pc;
    logic [2:0]       flags;
    logic [19:0]      sp;
    logic [15:0]      ivt_hi;
    logic [15:0]      ivt_lo;
    logic [4:0][3:0]  gd;     // grant delay per transaction: PCH,PCL,FLG,VH,VL
    logic [3:0]       rv;     // rvalid delay after grant, >= 1
    logic [2:0][19:0] ea;
    logic [2:0][15:0] ed;
    logic [31:0]      epc;
    int               elat;   // cycles from FLUSH through ACK inclusive
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt;
  logic        safe_point;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic [19:0] sp_in;
  logic        sp_dec, mem_req, mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;
  logic        stall, flush, pc_load, ack, busy;
  logic [31:0] pc_load_val;
`ifdef INTC_MASK_EN
  logic        int_mask;
`endif

  // Processor-side stack pointer: a base set by the test minus the decrements seen.
  logic [19:0] sp_base = 20'd0;
  logic [19:0] dec_total = 20'd0;
  assign sp_in = sp_base - dec_total;

  // Arbiter/memory configuration written by the test process.
  logic [4:0][3:0] gnt_dly = '0;
  logic [3:0]      rv_dly = 4'd1;
  logic [15:0]     ivt_hi = 16'd0, ivt_lo = 16'd0;

  // Monitor state, owned by the negedge process.
  logic [19:0] wq_addr[$];
  logic [15:0] wq_data[$];
  int cyc = 0, flush_cnt = 0, ack_cnt = 0, pcl_cnt = 0, spdec_cnt = 0;
  int rdreq_cnt = 0, rdgnt_cnt = 0, mon_err = 0, flush_cyc = 0, ack_cyc = 0;
  int txn_idx = 0, wait_cnt = 0, rv_left = 0;
  bit rv_pend = 0, prev_wait = 0, p_we = 0;
  logic [19:0] p_addr = '0;
  logic [15:0] p_wdata = '0, rv_data = '0;
  logic [31:0] pcl_last = '0;

  int errors = 0, checks = 0;

  interrupt_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .interrupt   (interrupt),
    .safe_point  (safe_point),
    .pc_in       (pc_in),
    .flags_in    (flags_in),
    .sp_in       (sp_in),
    .sp_dec      (sp_dec),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .flush       (flush),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .ack         (ack),
`ifdef INTC_MASK_EN
    .int_mask    (int_mask),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sp_dec) dec_total <= dec_total + 20'd1;

  // Arbiter and memory model, then a monitor sampled 1 time unit later.
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rv_pend) begin
      if (rv_left <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_data;
        rv_pend    = 1'b0;
      end else rv_left = rv_left - 1;
    end
    if (mem_req) begin
      if (wait_cnt >= ((txn_idx < 5) ? int'(gnt_dly[txn_idx]) : 0)) begin
        mem_gnt  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          wq_addr.push_back(mem_addr);
          wq_data.push_back(mem_wdata);
        end else begin
          rv_pend   = 1'b1;
          rv_left   = int'(rv_dly);
          rv_data   = (mem_addr == 20'd0) ? ivt_hi : (mem_addr == 20'd1) ? ivt_lo : 16'hDEAD;
          rdgnt_cnt = rdgnt_cnt + 1;
        end
        if (txn_idx < 5) txn_idx = txn_idx + 1;
      end else wait_cnt = wait_cnt + 1;
    end else wait_cnt = 0;

    #1;
    cyc = cyc + 1;
    if (flush)   begin flush_cnt = flush_cnt + 1; flush_cyc = cyc; txn_idx = 0; end
    if (ack)     begin ack_cnt = ack_cnt + 1; ack_cyc = cyc; end
    if (pc_load) begin pcl_cnt = pcl_cnt + 1; pcl_last = pc_load_val; end
    if (sp_dec)  spdec_cnt = spdec_cnt + 1;
    if (mem_req && !mem_we) rdreq_cnt = rdreq_cnt + 1;
    if (sp_dec && !(mem_gnt && mem_req && mem_we)) mon_err = mon_err + 1;
    if (!mem_req && (mem_addr != 20'd0 || mem_wdata != 16'd0)) mon_err = mon_err + 1;
    if (stall !== busy) mon_err = mon_err + 1;
    if (prev_wait && !rst &&
        (!mem_req || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata))
      mon_err = mon_err + 1;
    prev_wait = mem_req && !mem_gnt && !rst;
    p_we      = mem_we;
    p_addr    = mem_addr;
    p_wdata   = mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return flush_cnt;
      1:       return ack_cnt;
      default: return rdreq_cnt;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int prev, input int budget, input string name);
    int n = 0;
    while (cnt_of(sel) <= prev && n < budget) begin
      @(negedge clk); #2;
      n = n + 1;
    end
    check({name, " reached"}, 64'(cnt_of(sel) > prev), 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic [2:0] fl, input logic [19:0] sp,
                              input logic [15:0] hi, input logic [15:0] lo,
                              input logic [19:0] gd, input logic [3:0] rv,
                              input logic [19:0] a0, input logic [19:0] a1, input logic [19:0] a2,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                              input logic [31:0] epc, input int lat);
    vec_t v;
    v.pc = pc; v.flags = fl; v.sp = sp; v.ivt_hi = hi; v.ivt_lo = lo;
    v.gd = gd; v.rv = rv;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.epc = epc; v.elat = lat;
    return v;
  endfunction

  // Reference: three stack pushes below sp, vector = {hi,lo}, latency =
  // ten states plus every withheld grant cycle plus extra read wait cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   lat;
    r   = v;
    lat = 10;
    for (int i = 0; i < 3; i++) r.ea[i] = v.sp - 20'(i);
    r.ed[0] = v.pc[31:16];
    r.ed[1] = v.pc[15:0];
    r.ed[2] = {13'd0, v.flags};
    r.epc   = {v.ivt_hi, v.ivt_lo};
    for (int i = 0; i < 5; i++) lat = lat + int'(v.gd[i]);
    lat    = lat + 2 * (int'(v.rv) - 1);
    r.elat = lat;
    return r;
  endfunction

  task automatic setup(input vec_t v);
    sp_base  = v.sp + dec_total;
    pc_in    = v.pc;
    flags_in = v.flags;
    ivt_hi   = v.ivt_hi;
    ivt_lo   = v.ivt_lo;
    gnt_dly  = v.gd;
    rv_dly   = v.rv;
  endtask

  task automatic run_seq(input vec_t v, input bit rand_sp, input string tag);
    int w0, s0, p0, a0, f0, r0, e0, n;
    w0 = wq_addr.size(); s0 = spdec_cnt; p0 = pcl_cnt; a0 = ack_cnt;
    f0 = flush_cnt; r0 = rdgnt_cnt; e0 = mon_err;
    @(negedge clk);
    setup(v);
    interrupt  = 1'b1;
    safe_point = rand_sp ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
      interrupt = 1'b0;
      if (flush_cnt == f0) safe_point = (rand_sp && n < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
    end while (ack_cnt == a0 && n < 400);
    check({tag, " ack count"}, 64'(ack_cnt - a0), 64'd1);
    cycles(2);
    check({tag, " writes"}, 64'(wq_addr.size() - w0), 64'd3);
    if (wq_addr.size() >= w0 + 3)
      for (int i = 0; i < 3; i++)
        check($sformatf("%s push%0d addr/data", tag, i),
              64'({wq_addr[w0+i], wq_data[w0+i]}), 64'({v.ea[i], v.ed[i]}));
    check({tag, " sp_dec pulses"}, 64'(spdec_cnt - s0), 64'd3);
    check({tag, " reads"}, 64'(rdgnt_cnt - r0), 64'd2);
    check({tag, " pc_load count"}, 64'(pcl_cnt - p0), 64'd1);
    check({tag, " pc_load_val"}, 64'(pcl_last), 64'(v.epc));
    check({tag, " latency"}, 64'(ack_cyc - flush_cyc + 1), 64'(v.elat));
    check({tag, " protocol"}, 64'(mon_err - e0), 64'd0);
    check({tag, " idle after"}, 64'({busy, stall, mem_req}), 64'd0);
  endtask

  vec_t vecs[4];
  vec_t rv;
  int   f0, a0, p0, w0, r0;

  initial begin
    vecs[0] = mk(32'h0001_2345, 3'b101, 20'hFFFFF, 16'h0000, 16'h0200, 20'h00000, 4'd1,
                 20'hFFFFF, 20'hFFFFE, 20'hFFFFD, 16'h0001, 16'h2345, 16'h0005, 32'h0000_0200, 10);
    vecs[1] = mk(32'hCAFE_BEEF, 3'b010, 20'h00010, 16'h1234, 16'h5678, 20'h00040, 4'd1,
                 20'h00010, 20'h0000F, 20'h0000E, 16'hCAFE, 16'hBEEF, 16'h0002, 32'h1234_5678, 14);
    vecs[2] = mk(32'h8000_0001, 3'b111, 20'h00001, 16'hFFFF, 16'hFFFF, 20'h11111, 4'd2,
                 20'h00001, 20'h00000, 20'hFFFFF, 16'h8000, 16'h0001, 16'h0007, 32'hFFFF_FFFF, 17);
    vecs[3] = mk(32'h0000_0000, 3'b000, 20'h12345, 16'hA5A5, 16'h5A5A, 20'h13000, 4'd3,
                 20'h12345, 20'h12344, 20'h12343, 16'h0000, 16'h0000, 16'h0000, 32'hA5A5_5A5A, 18);

    rst = 1'b1; interrupt = 1'b0; safe_point = 1'b0; pc_in = '0; flags_in = '0;
`ifdef INTC_MASK_EN
    int_mask = 1'b0;
`endif
    cycles(1);
    check("reset outputs", 64'({busy, stall, flush, mem_req, mem_we, sp_dec, pc_load, ack}), 64'd0);
    check("reset pending", 64'(dut.u_pending.pending_q), 64'd0);
    rst = 1'b0;
    cycles(1);
    check("post-reset idle", 64'({busy, stall, mem_req, mem_addr, mem_wdata, pc_load_val}), 64'd0);

    for (int i = 0; i < 4; i++) run_seq(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Deferred entry: level held high, no safe point for 5 cycles.
    setup(vecs[0]);
    f0 = flush_cnt; a0 = ack_cnt;
    safe_point = 1'b0; interrupt = 1'b1;
    cycles(5);
    check("deferred no flush", 64'(flush_cnt - f0), 64'd0);
    check("deferred idle", 64'({busy, dut.u_pending.pending_q}), 64'b01);
    safe_point = 1'b1;
    wait_for(1, a0, 100, "deferred ack");
    cycles(10);
    check("held level single seq", 64'(flush_cnt - f0), 64'd1);
    interrupt = 1'b0;
    cycles(3);
    check("falling edge no seq", 64'(flush_cnt - f0), 64'd1);

    // Edge in the ACK cycle survives the clear and is serviced later.
    f0 = flush_cnt; a0 = ack_cnt;
    interrupt = 1'b1;
    cycles(1);
    interrupt = 1'b0;
    wait_for(0, f0, 20, "ackedge flush");
    safe_point = 1'b0;
    wait_for(1, a0, 100, "ackedge ack");
    interrupt = 1'b1;
    cycles(1);
    check("ackedge pending kept", 64'({dut.u_pending.pending_q, busy}), 64'b10);
    interrupt = 1'b0;
    cycles(3);
    check("ackedge waits safe_point", 64'(flush_cnt - f0), 64'd1);
    safe_point = 1'b1;
    wait_for(1, a0 + 1, 100, "ackedge second ack");
    check("ackedge two sequences", 64'(flush_cnt - f0), 64'd2);

    // Reset while the vector-high read is waiting for grant.
    rv = vecs[0];
    rv.gd = 20'h03000;
    setup(rv);
    r0 = rdreq_cnt; a0 = ack_cnt; p0 = pcl_cnt;
    interrupt = 1'b1;
    cycles(1);
    interrupt = 1'b0;
    wait_for(2, r0, 40, "reset reach RD_VH");
    rst = 1'b1;
    w0 = wq_addr.size(); r0 = rdgnt_cnt;
    cycles(1);
    check("midreset quiet", 64'({busy, stall, mem_req, dut.u_pending.pending_q}), 64'd0);
    rst = 1'b0;
    cycles(20);
    check("midreset no ack/load", 64'({ack_cnt - a0, pcl_cnt - p0}), 64'd0);
    check("midreset no memory", 64'({wq_addr.size() - w0, rdgnt_cnt - r0}), 64'd0);
    check("midreset idle", 64'(busy), 64'd0);

`ifdef INTC_MASK_EN
    setup(vecs[0]);
    f0 = flush_cnt; a0 = ack_cnt;
    int_mask = 1'b1; safe_point = 1'b1; interrupt = 1'b1;
    cycles(1);
    interrupt = 1'b0;
    cycles(5);
    check("mask blocks entry", 64'(flush_cnt - f0), 64'd0);
    check("mask keeps pending", 64'(dut.u_pending.pending_q), 64'd1);
    int_mask = 1'b0;
    cycles(1);
    check("unmask enters", 64'(flush), 64'd1);
    wait_for(1, a0, 100, "unmask ack");
`endif

    for (int k = 0; k < 20; k++) begin
      rv = '0;
      rv.pc     = $urandom;
      rv.flags  = 3'($urandom);
      rv.sp     = 20'($urandom);
      rv.ivt_hi = 16'($urandom);
      rv.ivt_lo = 16'($urandom);
      for (int j = 0; j < 5; j++) rv.gd[j] = 4'($urandom_range(0, 3));
      rv.rv = 4'($urandom_range(1, 3));
      run_seq(model(rv), 1'b1, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
